// File: rtl/xm23_int_pkg.sv
// rtl/xm23_int_pkg.sv - shared types and constants for the XM-23 interrupt controller
package xm23_int_pkg;

    localparam int          NDEV_DEF      = 5;
    localparam logic [3:0]  VECT_BASE_DEF = 4'd8;
    localparam logic [14:0] DEF_PRI_DEF   = 15'o76543;

    typedef enum logic [2:0] {
        TMR = 3'd0,
        KB  = 3'd1,
        SCR = 3'd2,
        TL  = 3'd3,
        PB  = 3'd4
    } dev_idx_e;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        PRI0 = 3'd0,
        PRI1 = 3'd1,
        PRI2 = 3'd2,
        PRI3 = 3'd3,
        PRI4 = 3'd4,
        PEND = 3'd5,
        OVF  = 3'd6,
        RSVD = 3'd7
    } cfg_addr_e;

endpackage

// File: rtl/xm23_int_ctrl_if.sv
// rtl/xm23_int_ctrl_if.sv - interrupt handshake and config register bus
// slave : controller side (drives int_req/int_vect/int_pri/cfg_rdata)
// master: CPU side (drives int_ack and the config strobes/address/data)
interface xm23_int_ctrl_if;
    logic       int_req;
    logic [3:0] int_vect;
    logic [2:0] int_pri;
    logic       int_ack;
    logic       cfg_we;
    logic       cfg_re;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    modport slave (
        input  int_ack, cfg_we, cfg_re, cfg_addr, cfg_wdata,
        output int_req, int_vect, int_pri, cfg_rdata
    );

    modport master (
        output int_ack, cfg_we, cfg_re, cfg_addr, cfg_wdata,
        input  int_req, int_vect, int_pri, cfg_rdata
    );
endinterface

// File: rtl/int_prio_arb.sv
// rtl/int_prio_arb.sv - combinational highest-priority picker, lowest index wins ties
// in : elig (eligible mask), pri (3 bits per source, source 0 in [2:0])
// out: any (some source eligible), win_idx, win_pri
module int_prio_arb #(
    parameter int NDEV = 5
) (
    input  logic [NDEV-1:0]   elig,
    input  logic [3*NDEV-1:0] pri,
    output logic              any,
    output logic [2:0]        win_idx,
    output logic [2:0]        win_pri
);
    always_comb begin
        any     = 1'b0;
        win_idx = 3'd0;
        win_pri = 3'd0;
        // Strict '>' keeps the earlier (lower) index on equal priority.
        for (int i = 0; i < NDEV; i++) begin
            if (elig[i] && (!any || (pri[3*i +: 3] > win_pri))) begin
                any     = 1'b1;
                win_idx = 3'(i);
                win_pri = pri[3*i +: 3];
            end
        end
    end
endmodule

// File: rtl/xm23_int_ctrl.sv
// rtl/xm23_int_ctrl.sv - priority interrupt controller for the XM-23 CPU
// Clock/Reset_n : clock, synchronous active-low reset
// dev_req/dev_ie: per-device request levels and interrupt enables
// cpu_pri       : current CPU priority
// bus           : interrupt handshake and config register port
module xm23_int_ctrl
    import xm23_int_pkg::*;
#(
    parameter int          NDEV      = NDEV_DEF,
    parameter logic [3:0]  VECT_BASE = VECT_BASE_DEF,
    parameter logic [14:0] DEF_PRI   = DEF_PRI_DEF
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [NDEV-1:0] dev_req,
    input  logic [NDEV-1:0] dev_ie,
    input  logic [2:0]      cpu_pri,
    xm23_int_ctrl_if.slave  bus
);
    logic [NDEV-1:0]   dev_req_q;
    logic [NDEV-1:0]   pend;
    logic [NDEV-1:0]   ovf;
    logic [3*NDEV-1:0] pri;
    state_e            state;
    logic [2:0]        win_idx;

    logic [NDEV-1:0]   edge_v;
    logic [NDEV-1:0]   elig;
    logic [NDEV-1:0]   ack_clr;
    logic [NDEV-1:0]   pend_w1c;
    logic [NDEV-1:0]   ovf_w1c;
    logic [7:0]        rd_data;
    logic              arb_any;
    logic [2:0]        arb_idx;
    logic [2:0]        arb_pri;

    always_comb begin
        edge_v = dev_req & ~dev_req_q;
        for (int i = 0; i < NDEV; i++) begin
            elig[i] = pend[i] & dev_ie[i] & (pri[3*i +: 3] > cpu_pri);
        end
        ack_clr = '0;
        if (state == REQ && bus.int_ack) begin
            ack_clr[win_idx] = 1'b1;
        end
        pend_w1c = (bus.cfg_we && bus.cfg_addr == PEND) ? bus.cfg_wdata[NDEV-1:0] : '0;
        ovf_w1c  = (bus.cfg_we && bus.cfg_addr == OVF)  ? bus.cfg_wdata[NDEV-1:0] : '0;
    end

    // Read mux sees pre-write state, so a same-cycle write is not visible.
    always_comb begin
        rd_data = 8'd0;
        for (int i = 0; i < NDEV; i++) begin
            if (bus.cfg_addr == 3'(i)) begin
                rd_data = {ovf[i], pend[i], 3'b000, pri[3*i +: 3]};
            end
        end
        if (bus.cfg_addr == PEND) rd_data = 8'(pend);
        if (bus.cfg_addr == OVF)  rd_data = 8'(ovf);
    end

    int_prio_arb #(.NDEV(NDEV)) u_arb (
        .elig    (elig),
        .pri     (pri),
        .any     (arb_any),
        .win_idx (arb_idx),
        .win_pri (arb_pri)
    );

    // A new edge always wins over ack/W1C clearing the same bit; overflow
    // only counts when the bit was pending and is not being cleared now.
    always_ff @(posedge Clock) begin
        // Tracking dev_req through reset means a level already high at
        // release is not mistaken for a fresh edge.
        dev_req_q <= dev_req;
        if (!Reset_n) begin
            pend          <= '0;
            ovf           <= '0;
            pri           <= DEF_PRI[3*NDEV-1:0];
            bus.cfg_rdata <= 8'd0;
        end else begin
            pend <= (pend & ~(ack_clr | pend_w1c)) | edge_v;
            ovf  <= (ovf & ~ovf_w1c) | (edge_v & pend & ~(ack_clr | pend_w1c));
            for (int i = 0; i < NDEV; i++) begin
                if (bus.cfg_we && bus.cfg_addr == 3'(i)) begin
                    pri[3*i +: 3] <= bus.cfg_wdata[2:0];
                end
            end
            if (bus.cfg_re) begin
                bus.cfg_rdata <= rd_data;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state        <= IDLE;
            win_idx      <= 3'd0;
            bus.int_req  <= 1'b0;
            bus.int_vect <= 4'd0;
            bus.int_pri  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state        <= REQ;
                        win_idx      <= arb_idx;
                        bus.int_req  <= 1'b1;
                        bus.int_vect <= VECT_BASE + {1'b0, arb_idx};
                        bus.int_pri  <= arb_pri;
                    end
                end
                REQ: begin
                    // Presented vector stays frozen; only ack or loss of the
                    // winner's pend/enable ends the request.
                    if (bus.int_ack || !pend[win_idx] || !dev_ie[win_idx]) begin
                        state       <= IDLE;
                        bus.int_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.int_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xm23_int_ctrl.sv
// tb/tb_xm23_int_ctrl.sv - directed self-checking bench for xm23_int_ctrl
module tb_xm23_int_ctrl;
    localparam logic [14:0] DEF_PRI = 15'o76543;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic [4:0] dev_req;
    logic [4:0] dev_ie;
    logic [2:0] cpu_pri;
    logic [14:0] def_pri_v;

    int checks   = 0;
    int failures = 0;

    xm23_int_ctrl_if bus ();

    xm23_int_ctrl dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .dev_req (dev_req),
        .dev_ie  (dev_ie),
        .cpu_pri (cpu_pri),
        .bus     (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [7:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] addr);
        bus.cfg_re   = 1'b1;
        bus.cfg_addr = addr;
        tick();
        bus.cfg_re   = 1'b0;
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    initial begin
        def_pri_v     = DEF_PRI;
        Reset_n       = 1'b0;
        dev_req       = '0;
        dev_ie        = '1;
        cpu_pri       = 3'd0;
        bus.int_ack   = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_re    = 1'b0;
        bus.cfg_addr  = 3'd0;
        bus.cfg_wdata = 8'd0;
        tick();
        tick();
        check("rst_req",   8'(bus.int_req), 8'd0);
        check("rst_vect",  8'(bus.int_vect), 8'd0);
        check("rst_pri",   8'(bus.int_pri), 8'd0);
        check("rst_rdata", bus.cfg_rdata, 8'd0);
        Reset_n = 1'b1;
        tick();

        // single device (kb), default priority
        dev_req[1] = 1'b1;
        tick();
        check("kb_lat1", 8'(bus.int_req), 8'd0);
        dev_req[1] = 1'b0;
        tick();
        check("kb_req",  8'(bus.int_req), 8'd1);
        check("kb_vect", 8'(bus.int_vect), 8'd9);
        check("kb_pri",  8'(bus.int_pri), 8'(def_pri_v[5:3]));
        ack();
        check("kb_ack_low", 8'(bus.int_req), 8'd0);
        cfg_read(3'd5);
        check("kb_pend_clr", bus.cfg_rdata, 8'h00);

        // two devices, distinct priorities then a tie
        cfg_write(3'd0, 8'd7);
        cfg_write(3'd4, 8'd3);
        dev_req = 5'b10001;
        tick();
        dev_req = 5'b00000;
        tick();
        check("two_v1",   8'(bus.int_vect), 8'd8);
        check("two_p1",   8'(bus.int_pri), 8'd7);
        ack();
        check("two_idle", 8'(bus.int_req), 8'd0);
        tick();
        check("two_req2", 8'(bus.int_req), 8'd1);
        check("two_v2",   8'(bus.int_vect), 8'd12);
        check("two_p2",   8'(bus.int_pri), 8'd3);
        ack();
        cfg_write(3'd4, 8'd7);
        dev_req = 5'b10001;
        tick();
        dev_req = 5'b00000;
        tick();
        check("tie_v1", 8'(bus.int_vect), 8'd8);
        ack();
        tick();
        check("tie_v2", 8'(bus.int_vect), 8'd12);
        check("tie_p2", 8'(bus.int_pri), 8'd7);
        ack();

        // cpu priority masking (scr default pri 5)
        cpu_pri    = 3'd5;
        dev_req[2] = 1'b1;
        tick();
        dev_req[2] = 1'b0;
        tick();
        tick();
        check("mask_req", 8'(bus.int_req), 8'd0);
        cpu_pri = 3'd4;
        tick();
        check("unmask_req",  8'(bus.int_req), 8'd1);
        check("unmask_vect", 8'(bus.int_vect), 8'd10);
        ack();
        cpu_pri = 3'd0;

        // overflow, read-back, W1C withdraw
        cfg_write(3'd3, 8'd1);
        dev_req[3] = 1'b1;
        tick();
        dev_req[3] = 1'b0;
        tick();
        check("tl_vect", 8'(bus.int_vect), 8'd11);
        dev_req[3] = 1'b1;
        tick();
        dev_req[3] = 1'b0;
        cfg_read(3'd3);
        check("tl_rd",   bus.cfg_rdata, 8'hC1);
        check("tl_hold", 8'(bus.int_req), 8'd1);
        cfg_write(3'd5, 8'h08);
        tick();
        check("tl_withdraw", 8'(bus.int_req), 8'd0);
        cfg_write(3'd6, 8'h08);
        cfg_read(3'd6);
        check("ovf_clr", bus.cfg_rdata, 8'h00);

        // ack and new edge on the same device in the same cycle
        dev_req[3] = 1'b1;
        tick();
        dev_req[3] = 1'b0;
        tick();
        check("race_req", 8'(bus.int_req), 8'd1);
        bus.int_ack = 1'b1;
        dev_req[3]  = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        dev_req[3]  = 1'b0;
        check("race_low", 8'(bus.int_req), 8'd0);
        cfg_read(3'd3);
        check("race_rd",   bus.cfg_rdata, 8'h41);
        check("race_re",   8'(bus.int_req), 8'd1);
        check("race_vect", 8'(bus.int_vect), 8'd11);
        ack();

        // reset in REQ with dev_req held high
        dev_req[2] = 1'b1;
        tick();
        tick();
        check("pre_rst_req", 8'(bus.int_req), 8'd1);
        Reset_n = 1'b0;
        tick();
        check("mid_rst_req",   8'(bus.int_req), 8'd0);
        check("mid_rst_vect",  8'(bus.int_vect), 8'd0);
        check("mid_rst_pri",   8'(bus.int_pri), 8'd0);
        check("mid_rst_rdata", bus.cfg_rdata, 8'd0);
        Reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_noreq", 8'(bus.int_req), 8'd0);
        bus.cfg_we    = 1'b1;
        bus.cfg_re    = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_wdata = 8'd2;
        tick();
        bus.cfg_we = 1'b0;
        bus.cfg_re = 1'b0;
        check("rw_same_cycle", bus.cfg_rdata, 8'(def_pri_v[2:0]));
        cfg_read(3'd0);
        check("rw_after", bus.cfg_rdata, 8'h02);
        cfg_read(3'd7);
        check("addr7", bus.cfg_rdata, 8'h00);
        dev_req[2] = 1'b0;
        tick();
        dev_req[2] = 1'b1;
        tick();
        tick();
        check("fresh_req",  8'(bus.int_req), 8'd1);
        check("fresh_vect", 8'(bus.int_vect), 8'd10);
        check("fresh_pri",  8'(bus.int_pri), 8'(def_pri_v[8:6]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
